pc_run_ctrl: RTL and testbench
==============================

// Module: pc_run_ctrl
// PURPOSE
// - Run-control sequencer for the fetch PC register: drives its Stall and Continue inputs.
// - Halts on debug request, address breakpoint or decoded break instruction.
// - Single-steps N instructions, then resumes. Sits between debug host, hazard unit and PC.
// - PC restore after a break instruction is done by pulsing Continue.
// PARAMETERS
// - NUM_BP  4   number of address breakpoint slots
// - AW      32  PC / breakpoint address width
// - STEP_W  8   width of single-step count
// PORTS
// - clk           in   1        system clock, rising edge
// - rst_n         in   1        synchronous, active-low reset
// - hazard_stall  in   1        pipeline hazard stall request
// - pc_cur        in   AW       current PC (PCNext of PC register)
// - ex_break      in   1        break instruction decoded (PCSrc==2'b11 cycle)
// - dbg_halt_req  in   1        host halt request, level
// - dbg_resume    in   1        host resume, 1-cycle pulse
// - dbg_step      in   1        host step, 1-cycle pulse
// - step_count    in   STEP_W   instructions per step; 0 treated as 1
// - bp_wr         in   1        breakpoint slot write strobe
// - bp_idx        in   log2(NUM_BP)  slot index
// - bp_addr       in   AW       slot address
// - bp_en         in   1        slot enable written with address
// - pc_stall      out  1        to PC Stall
// - pc_continue   out  1        to PC Continue, 1-cycle pulse
// - halted        out  1        core halted
// - halt_cause    out  2        00 none, 01 host, 10 bp, 11 break/step (see below)
// - step_done     out  1        1-cycle pulse when step sequence finishes
// BEHAVIOUR
// - Reset: state RUN, all outputs 0, all bp slots disabled, step counter 0, skip flag 0.
// - States: RUN, HALTED, STEP, RESUME (one-hot or binary, implementer's choice).
// - hit = OR over enabled slots of (pc_cur == slot addr), masked by skip flag.
// - RUN: pc_stall = hazard_stall | hit | dbg_halt_req | ex_break (combinational).
//   - Any of ex_break/hit/dbg_halt_req -> HALTED next edge.
//   - Cause priority: ex_break(11) > hit(10) > host(01).
// - HALTED: pc_stall=1, halted=1 (registered), halt_cause held.
//   - dbg_step has priority over dbg_resume when both pulse in the same cycle.
//   - dbg_step -> STEP; counter loaded with max(step_count,1).
//   - dbg_resume -> RESUME.
//   - dbg_halt_req held high does not block leaving HALTED.
// - STEP: pc_stall=hazard_stall; counter decrements on each cycle with !hazard_stall.
//   - On decrement from 1: -> HALTED, step_done=1 that cycle, halt_cause=2'b11.
//   - ex_break during STEP -> HALTED with cause 11, step_done=0.
//   - Breakpoints are ignored in STEP.
// - RESUME (exactly 1 cycle): pc_stall=1, then -> RUN.
//   - pc_continue=1 only if halt_cause==11 and the halt came from ex_break.
//   - Track break vs step origin in one internal bit.
//   - Skip flag set: suppresses hit while pc_cur equals PC captured at halt.
//   - Skip flag clears on first PC change.
// - Breakpoint writes are accepted in any state and take effect the next cycle.
// - Write to an out-of-range index is ignored.
// - Leaving HALTED clears halted; halt_cause is held until the next halt.
// - step_done and pc_continue are never high in the same cycle.
// - rst_n low in any state: next edge returns to reset values; no pulse is emitted.
// STRUCTURE
// - Package pc_dbg_pkg:
//   - state enum
//   - halt_cause codes (CAUSE_NONE/HOST/BP/BRK)
//   - PC_BREAK = 32'hffffffff
// - Sub-module pc_bp_match: NUM_BP slot registers, write port, combinational hit output.
// - FSM, step counter and skip logic live in pc_run_ctrl.
// TESTING
// - Host halt: dbg_halt_req=1 in RUN -> pc_stall same cycle, halted=1 next cycle, cause=01.
// - Breakpoint: slot0=0x40 enabled, pc_cur reaches 0x40 -> halted, cause=10.
//   - Then resume -> runs past 0x40 without re-halting.
// - Break: ex_break=1 -> halted, cause=11.
//   - dbg_resume -> pc_continue high exactly 1 cycle, then RUN.
// - Step: halted, step_count=3, dbg_step, hazard_stall high 2 cycles mid-way.
//   - Expect 3 unstalled cycles, then step_done pulse and halted=1.
// - Step with step_count=0: halted, dbg_step -> exactly 1 unstalled cycle, then halted.
// - Simultaneous/reset: dbg_step+dbg_resume same cycle -> STEP.
//   - rst_n low during STEP -> RUN, bp slots cleared, no step_done.

Source files
------------

// File: rtl/pc_dbg_pkg.sv
// pc_dbg_pkg: shared run-control state, halt cause codes and constants
package pc_dbg_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_STEP, ST_RESUME} state_t;
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_HOST = 2'b01;
  localparam logic [1:0] CAUSE_BP   = 2'b10;
  localparam logic [1:0] CAUSE_BRK  = 2'b11;
  localparam logic [31:0] PC_BREAK = 32'hffffffff;
endpackage

// File: rtl/pc_bp_match.sv
// pc_bp_match: address breakpoint slot registers with combinational PC match
module pc_bp_match #(
  parameter int NUM_BP = 4,
  parameter int AW = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr,
  input  logic [$clog2(NUM_BP)-1:0] idx,
  input  logic [AW-1:0]             addr,
  input  logic                      en,
  input  logic [AW-1:0]             pc,
  output logic                      hit
);
  localparam int IW = $clog2(NUM_BP);
  logic [AW-1:0] slot_addr [NUM_BP];
  logic [NUM_BP-1:0] slot_en;
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BP; i++) begin
      if (!rst_n) begin
        slot_addr[i] <= '0;
        slot_en[i] <= 1'b0;
      end else if (wr && idx == IW'(i)) begin
        slot_addr[i] <= addr;
        slot_en[i] <= en;
      end
    end
  end
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_BP; i++) hit = hit | (slot_en[i] && slot_addr[i] == pc);
  end
endmodule

// File: rtl/pc_run_ctrl.sv
// pc_run_ctrl: run-control sequencer driving the fetch PC stall and continue inputs
module pc_run_ctrl
  import pc_dbg_pkg::*;
#(
  parameter int NUM_BP = 4,
  parameter int AW = 32,
  parameter int STEP_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      hazard_stall,
  input  logic [AW-1:0]             pc_cur,
  input  logic                      ex_break,
  input  logic                      dbg_halt_req,
  input  logic                      dbg_resume,
  input  logic                      dbg_step,
  input  logic [STEP_W-1:0]         step_count,
  input  logic                      bp_wr,
  input  logic [$clog2(NUM_BP)-1:0] bp_idx,
  input  logic [AW-1:0]             bp_addr,
  input  logic                      bp_en,
  output logic                      pc_stall,
  output logic                      pc_continue,
  output logic                      halted,
  output logic [1:0]                halt_cause,
  output logic                      step_done
);
  state_t state, state_n;
  logic [1:0] cause_n;
  logic brk_org, org_n, skip, raw_hit, hit;
  logic [STEP_W-1:0] cnt, cnt_n;
  logic [AW-1:0] halt_pc;
  pc_bp_match #(.NUM_BP(NUM_BP), .AW(AW)) u_bp (
    .clk(clk), .rst_n(rst_n), .wr(bp_wr), .idx(bp_idx), .addr(bp_addr),
    .en(bp_en), .pc(pc_cur), .hit(raw_hit)
  );
  // the instruction we halted on must be allowed to execute once after resume
  assign hit = raw_hit & ~(skip & (pc_cur == halt_pc));
  assign halted = (state == ST_HALTED);
  always_comb begin
    state_n = state;
    cause_n = halt_cause;
    org_n = brk_org;
    cnt_n = cnt;
    pc_stall = 1'b1;
    pc_continue = 1'b0;
    step_done = 1'b0;
    case (state)
      ST_RUN: begin
        pc_stall = hazard_stall | hit | dbg_halt_req | ex_break;
        if (ex_break | hit | dbg_halt_req) begin
          state_n = ST_HALTED;
          cause_n = ex_break ? CAUSE_BRK : hit ? CAUSE_BP : CAUSE_HOST;
          org_n = ex_break;
        end
      end
      ST_HALTED: begin
        if (dbg_step) begin
          state_n = ST_STEP;
          cnt_n = (|step_count) ? step_count : STEP_W'(1);
        end else if (dbg_resume) state_n = ST_RESUME;
      end
      ST_STEP: begin
        pc_stall = hazard_stall;
        if (ex_break) begin
          state_n = ST_HALTED;
          cause_n = CAUSE_BRK;
          org_n = 1'b1;
        end else if (!hazard_stall) begin
          cnt_n = cnt - STEP_W'(1);
          if (cnt == STEP_W'(1)) begin
            state_n = ST_HALTED;
            cause_n = CAUSE_BRK;
            org_n = 1'b0;
            step_done = 1'b1;
          end
        end
      end
      ST_RESUME: begin
        state_n = ST_RUN;
        pc_continue = (halt_cause == CAUSE_BRK) && brk_org;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
      halt_cause <= CAUSE_NONE;
      brk_org <= 1'b0;
      cnt <= '0;
      skip <= 1'b0;
      halt_pc <= AW'(PC_BREAK);
    end else begin
      state <= state_n;
      halt_cause <= cause_n;
      brk_org <= org_n;
      cnt <= cnt_n;
      skip <= (state == ST_RESUME) ? 1'b1 : (pc_cur != halt_pc) ? 1'b0 : skip;
      if (state_n == ST_HALTED && state != ST_HALTED) halt_pc <= pc_cur;
    end
  end
endmodule

// File: tb/tb_pc_run_ctrl.sv
// tb_pc_run_ctrl: directed table, corner sequences and random run against a behavioural model
module tb_pc_run_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, hazard_stall, ex_break, dbg_halt_req, dbg_resume, dbg_step, bp_wr, bp_en;
  logic [31:0] pc_cur, bp_addr;
  logic [7:0] step_count;
  logic [1:0] bp_idx, halt_cause;
  logic pc_stall, pc_continue, halted, step_done;

  pc_run_ctrl dut (
    .clk(clk), .rst_n(rst_n), .hazard_stall(hazard_stall), .pc_cur(pc_cur),
    .ex_break(ex_break), .dbg_halt_req(dbg_halt_req), .dbg_resume(dbg_resume),
    .dbg_step(dbg_step), .step_count(step_count), .bp_wr(bp_wr), .bp_idx(bp_idx),
    .bp_addr(bp_addr), .bp_en(bp_en), .pc_stall(pc_stall), .pc_continue(pc_continue),
    .halted(halted), .halt_cause(halt_cause), .step_done(step_done)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: halted flag, remaining step budget, resume cycle flag
  bit m_h, m_res, m_brk, m_sk;
  int m_left, m_cause;
  logic [31:0] m_hp;
  logic [31:0] m_a [4];
  bit m_e [4];

  function automatic void m_reset();
    m_h = 0; m_res = 0; m_brk = 0; m_sk = 0; m_left = 0; m_cause = 0; m_hp = 32'hffffffff;
    for (int j = 0; j < 4; j++) begin m_a[j] = 0; m_e[j] = 0; end
  endfunction

  function automatic bit m_hit();
    bit h = 0;
    for (int j = 0; j < 4; j++) if (m_e[j] && m_a[j] == pc_cur) h = 1;
    return h && !(m_sk && pc_cur == m_hp);
  endfunction

  function automatic void m_halt(input int c, input bit b);
    m_h = 1; m_left = 0; m_cause = c; m_brk = b; m_hp = pc_cur;
  endfunction

  task automatic idle();
    rst_n = 1; hazard_stall = 0; ex_break = 0; dbg_halt_req = 0; dbg_resume = 0;
    dbg_step = 0; step_count = 0; bp_wr = 0; bp_idx = 0; bp_addr = 0; bp_en = 0;
  endtask

  task automatic sample(input string tag);
    bit st, ct, sd;
    @(negedge clk);
    ct = 0; sd = 0;
    if (m_res) begin st = 1; ct = (m_cause == 3) && m_brk; end
    else if (m_h) st = 1;
    else if (m_left > 0) begin st = hazard_stall; sd = !ex_break && !hazard_stall && m_left == 1; end
    else st = hazard_stall | m_hit() | dbg_halt_req | ex_break;
    chk($sformatf("%s.pc_stall", tag), 32'(pc_stall), 32'(st));
    chk($sformatf("%s.pc_continue", tag), 32'(pc_continue), 32'(ct));
    chk($sformatf("%s.step_done", tag), 32'(step_done), 32'(sd));
    chk($sformatf("%s.halted", tag), 32'(halted), 32'(m_h));
    chk($sformatf("%s.halt_cause", tag), 32'(halt_cause), m_cause);
  endtask

  task automatic edge_upd();
    bit hit;
    @(posedge clk);
    if (!rst_n) m_reset();
    else begin
      hit = m_hit();
      if (m_res) m_sk = 1; else if (pc_cur != m_hp) m_sk = 0;
      if (m_res) m_res = 0;
      else if (m_h) begin
        if (dbg_step) begin m_h = 0; m_left = (step_count == 0) ? 1 : int'(step_count); end
        else if (dbg_resume) begin m_h = 0; m_res = 1; end
      end else if (m_left > 0) begin
        if (ex_break) m_halt(3, 1);
        else if (!hazard_stall) begin
          if (m_left == 1) m_halt(3, 0); else m_left--;
        end
      end else if (ex_break || hit || dbg_halt_req) m_halt(ex_break ? 3 : hit ? 2 : 1, ex_break);
      if (bp_wr) begin m_a[bp_idx] = bp_addr; m_e[bp_idx] = bp_en; end
    end
    #1;
  endtask

  typedef struct {
    logic rst_n, hz, eb, hr, res, stp;
    logic [7:0] sc;
    logic [31:0] pc;
    logic wr;
    logic [31:0] addr;
    logic stall, cont, hlt;
    logic [1:0] cause;
    logic sd;
  } vec_t;
  vec_t tbl [20];

  initial begin
    int unst;
    bit done;
    tbl[0]  = '{1,0,0,1,0,0,8'd0,32'h10,0,32'h0,  1,0,0,2'd0,0};
    tbl[1]  = '{1,0,0,1,0,0,8'd0,32'h10,0,32'h0,  1,0,1,2'd1,0};
    tbl[2]  = '{1,0,0,1,1,0,8'd0,32'h10,0,32'h0,  1,0,1,2'd1,0};
    tbl[3]  = '{1,0,0,0,0,0,8'd0,32'h10,0,32'h0,  1,0,0,2'd1,0};
    tbl[4]  = '{1,0,0,0,0,0,8'd0,32'h20,1,32'h40, 0,0,0,2'd1,0};
    tbl[5]  = '{1,0,0,0,0,0,8'd0,32'h40,0,32'h0,  1,0,0,2'd1,0};
    tbl[6]  = '{1,0,0,0,1,0,8'd0,32'h40,0,32'h0,  1,0,1,2'd2,0};
    tbl[7]  = '{1,0,0,0,0,0,8'd0,32'h40,0,32'h0,  1,0,0,2'd2,0};
    tbl[8]  = '{1,0,0,0,0,0,8'd0,32'h40,0,32'h0,  0,0,0,2'd2,0};
    tbl[9]  = '{1,0,0,0,0,0,8'd0,32'h44,0,32'h0,  0,0,0,2'd2,0};
    tbl[10] = '{1,0,1,0,0,0,8'd0,32'h48,0,32'h0,  1,0,0,2'd2,0};
    tbl[11] = '{1,0,0,0,1,1,8'd0,32'h48,0,32'h0,  1,0,1,2'd3,0};
    tbl[12] = '{1,1,0,0,0,0,8'd0,32'h48,0,32'h0,  1,0,0,2'd3,0};
    tbl[13] = '{1,0,0,0,0,0,8'd0,32'h48,0,32'h0,  0,0,0,2'd3,1};
    tbl[14] = '{1,0,0,0,1,0,8'd0,32'h4c,0,32'h0,  1,0,1,2'd3,0};
    tbl[15] = '{1,0,0,0,0,0,8'd0,32'h4c,0,32'h0,  1,0,0,2'd3,0};
    tbl[16] = '{1,0,1,0,0,0,8'd0,32'h50,0,32'h0,  1,0,0,2'd3,0};
    tbl[17] = '{1,0,0,0,1,0,8'd0,32'h50,0,32'h0,  1,0,1,2'd3,0};
    tbl[18] = '{1,0,0,0,0,0,8'd0,32'h50,0,32'h0,  1,1,0,2'd3,0};
    tbl[19] = '{1,0,0,0,0,0,8'd0,32'h54,0,32'h0,  0,0,0,2'd3,0};
    idle();
    pc_cur = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    sample("reset");
    chk("reset.stall", 32'(pc_stall), 0);
    chk("reset.halted", 32'(halted), 0);
    chk("reset.cause", 32'(halt_cause), 0);
    edge_upd();
    for (int i = 0; i < 20; i++) begin
      idle();
      rst_n = tbl[i].rst_n; hazard_stall = tbl[i].hz; ex_break = tbl[i].eb;
      dbg_halt_req = tbl[i].hr; dbg_resume = tbl[i].res; dbg_step = tbl[i].stp;
      step_count = tbl[i].sc; pc_cur = tbl[i].pc; bp_wr = tbl[i].wr; bp_addr = tbl[i].addr; bp_en = 1;
      sample($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.stall", i), 32'(pc_stall), 32'(tbl[i].stall));
      chk($sformatf("tbl%0d.cont", i), 32'(pc_continue), 32'(tbl[i].cont));
      chk($sformatf("tbl%0d.halted", i), 32'(halted), 32'(tbl[i].hlt));
      chk($sformatf("tbl%0d.cause", i), 32'(halt_cause), 32'(tbl[i].cause));
      chk($sformatf("tbl%0d.step_done", i), 32'(step_done), 32'(tbl[i].sd));
      edge_upd();
    end
    // step of 3 with a two-cycle hazard stall in the middle
    idle(); pc_cur = 32'h60; dbg_halt_req = 1;
    sample("s3.halt"); edge_upd();
    idle(); pc_cur = 32'h60; dbg_step = 1; step_count = 3;
    sample("s3.go"); edge_upd();
    unst = 0; done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      idle(); pc_cur = 32'h60 + 32'(4 * k); hazard_stall = (k == 1 || k == 2);
      sample("s3.run");
      if (pc_stall === 1'b0) unst++;
      if (step_done === 1'b1) done = 1;
      edge_upd();
    end
    chk("s3.step_done_seen", 32'(done), 1);
    chk("s3.unstalled_cycles", unst, 3);
    idle(); pc_cur = 32'h70;
    sample("s3.after");
    chk("s3.halted", 32'(halted), 1);
    chk("s3.cause", 32'(halt_cause), 3);
    // reset while stepping
    dbg_step = 1; dbg_resume = 1; step_count = 10;
    edge_upd();
    idle(); pc_cur = 32'h74;
    sample("rs.step1"); edge_upd();
    sample("rs.step2"); edge_upd();
    rst_n = 0;
    sample("rs.reset");
    chk("rs.no_step_done", 32'(step_done), 0);
    edge_upd();
    idle(); pc_cur = 32'h40;
    sample("rs.after");
    chk("rs.stall_bp_cleared", 32'(pc_stall), 0);
    chk("rs.halted", 32'(halted), 0);
    chk("rs.cause", 32'(halt_cause), 0);
    edge_upd();
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      hazard_stall = ($urandom_range(0, 3) == 0);
      pc_cur = 32'h40 + 32'(4 * $urandom_range(0, 3));
      ex_break = ($urandom_range(0, 15) == 0);
      dbg_halt_req = ($urandom_range(0, 11) == 0);
      dbg_resume = ($urandom_range(0, 5) == 0);
      dbg_step = ($urandom_range(0, 7) == 0);
      step_count = 8'($urandom_range(0, 4));
      bp_wr = ($urandom_range(0, 7) == 0);
      bp_idx = 2'($urandom_range(0, 3));
      bp_addr = 32'h40 + 32'(4 * $urandom_range(0, 3));
      bp_en = 1'($urandom_range(0, 1));
      sample("rnd");
      edge_upd();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
